// File: rtl/instr_encoder.sv
// RV32I instruction encoder: field bundle in, 32-bit instruction word out, two-stage pipeline.
// Define INSTR_ENCODER_RV32M_EN to accept the RV32M multiply/divide R-type group.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  op,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [9:0]  func,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    output logic [15:0] enc_cnt,
    output logic [15:0] err_cnt
);

`ifdef INSTR_ENCODER_RV32M_EN
    localparam logic RV32M = 1'b1;
`else
    localparam logic RV32M = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [3:0] FMT_R    = 4'd0;
    localparam logic [3:0] FMT_I    = 4'd1;
    localparam logic [3:0] FMT_SH   = 4'd2;
    localparam logic [3:0] FMT_LD   = 4'd3;
    localparam logic [3:0] FMT_JALR = 4'd4;
    localparam logic [3:0] FMT_S    = 4'd5;
    localparam logic [3:0] FMT_B    = 4'd6;
    localparam logic [3:0] FMT_U    = 4'd7;
    localparam logic [3:0] FMT_J    = 4'd8;
    localparam logic [3:0] FMT_BAD  = 4'd9;

    logic        s1_valid;
    logic [3:0]  s1_fmt;
    logic [6:0]  s1_op;
    logic [4:0]  s1_rs1, s1_rs2, s1_rd;
    logic [6:0]  s1_f7;
    logic [2:0]  s1_f3;
    logic [31:0] s1_imm;

    logic        s2_valid;
    logic [31:0] s2_instr;
    logic        s2_err;

    logic        s1_adv;
    logic        in_fire;
    logic        out_fire;
    logic [3:0]  in_fmt;
    logic [31:0] asm_word;
    logic        asm_ok;
    logic        imm12_ok, imm13_ok, imm21_ok;

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = rst_n && (!s1_valid || s1_adv);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = s2_valid && out_ready;
    assign out_valid = s2_valid;
    assign out_instr = s2_instr;
    assign out_err   = s2_err;

    // Shifts are the only OP-IMM encodings that carry funct7, so they get their own class.
    always_comb begin
        in_fmt = FMT_BAD;
        case (op)
            7'b0110011: in_fmt = FMT_R;
            7'b0010011: in_fmt = (func[1:0] == 2'b01) ? FMT_SH : FMT_I;
            7'b0000011: in_fmt = FMT_LD;
            7'b1100111: in_fmt = FMT_JALR;
            7'b0100011: in_fmt = FMT_S;
            7'b1100011: in_fmt = FMT_B;
            7'b0110111: in_fmt = FMT_U;
            7'b1101111: in_fmt = FMT_J;
            default:    in_fmt = FMT_BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_fmt <= in_fmt;
            s1_op  <= op;
            s1_rs1 <= rs1;
            s1_rs2 <= rs2;
            s1_rd  <= rd;
            s1_f7  <= func[9:3];
            s1_f3  <= func[2:0];
            s1_imm <= imm;
        end
    end

    // Upper immediate bits must all match the sign bit to fit the field.
    assign imm12_ok = (&s1_imm[31:11]) || !(|s1_imm[31:11]);
    assign imm13_ok = ((&s1_imm[31:12]) || !(|s1_imm[31:12])) && !s1_imm[0];
    assign imm21_ok = ((&s1_imm[31:20]) || !(|s1_imm[31:20])) && !s1_imm[0];

    always_comb begin
        asm_word = {s1_imm[11:0], s1_rs1, s1_f3, s1_rd, s1_op};
        asm_ok   = 1'b0;
        case (s1_fmt)
            FMT_R: begin
                asm_word = {s1_f7, s1_rs2, s1_rs1, s1_f3, s1_rd, s1_op};
                asm_ok   = (s1_f7 == 7'b0000000)
                        || (s1_f7 == 7'b0100000 && (s1_f3 == 3'b000 || s1_f3 == 3'b101))
                        || (s1_f7 == 7'b0000001 && RV32M);
            end
            FMT_I:    asm_ok = imm12_ok;
            FMT_SH: begin
                asm_word = {s1_f7, s1_imm[4:0], s1_rs1, s1_f3, s1_rd, s1_op};
                asm_ok   = !(|s1_imm[31:5])
                        && (s1_f7 == 7'b0000000 || (s1_f7 == 7'b0100000 && s1_f3 == 3'b101));
            end
            FMT_LD:   asm_ok = imm12_ok && s1_f3 != 3'b011 && s1_f3 != 3'b110 && s1_f3 != 3'b111;
            FMT_JALR: asm_ok = imm12_ok && s1_f3 == 3'b000;
            FMT_S: begin
                asm_word = {s1_imm[11:5], s1_rs2, s1_rs1, s1_f3, s1_imm[4:0], s1_op};
                asm_ok   = imm12_ok && s1_f3 < 3'b011;
            end
            FMT_B: begin
                asm_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, s1_f3,
                            s1_imm[4:1], s1_imm[11], s1_op};
                asm_ok   = imm13_ok && s1_f3 != 3'b010 && s1_f3 != 3'b011;
            end
            FMT_U: begin
                asm_word = {s1_imm[31:12], s1_rd, s1_op};
                asm_ok   = !(|s1_imm[11:0]);
            end
            FMT_J: begin
                asm_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], s1_rd, s1_op};
                asm_ok   = imm21_ok;
            end
            default:  asm_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= asm_ok ? asm_word : NOP;
                s2_err   <= !asm_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (in_fire && enc_cnt != 16'hFFFF) enc_cnt <= enc_cnt + 16'd1;
            if (out_fire && s2_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, backpressure, random stream, reset.
// Honours INSTR_ENCODER_RV32M_EN the same way the design does.
module tb_instr_encoder;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [9:0]  func;
        logic [31:0] imm;
    } bundle_t;

`ifdef INSTR_ENCODER_RV32M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  func;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_cnt;
    logic [15:0] err_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [32:0] exp_q[$];
    int          exp_enc = 0;
    int          exp_err = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .enc_cnt   (enc_cnt),
        .err_cnt   (err_cnt)
    );

    // Reference: decide legality from value ranges and allowed funct sets, then pack the fields.
    function automatic logic [32:0] ref_encode(input bundle_t b);
        int          s;
        bit          ok;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] w;
        s  = $signed(b.imm);
        f7 = b.func[9:3];
        f3 = b.func[2:0];
        ok = 1'b0;
        w  = '0;
        case (b.op)
            7'b0110011: begin
                ok = (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'd1 && M_EN);
                w  = {f7, b.rs2, b.rs1, f3, b.rd, b.op};
            end
            7'b0010011: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    ok = (b.imm < 32) && (f7 == 7'd0 || (f3 == 3'd5 && f7 == 7'h20));
                    w  = {f7, b.imm[4:0], b.rs1, f3, b.rd, b.op};
                end else begin
                    ok = (s >= -2048 && s <= 2047);
                    w  = {b.imm[11:0], b.rs1, f3, b.rd, b.op};
                end
            end
            7'b0000011: begin
                ok = (s >= -2048 && s <= 2047) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                w  = {b.imm[11:0], b.rs1, f3, b.rd, b.op};
            end
            7'b1100111: begin
                ok = (s >= -2048 && s <= 2047) && (f3 == 3'd0);
                w  = {b.imm[11:0], b.rs1, f3, b.rd, b.op};
            end
            7'b0100011: begin
                ok = (s >= -2048 && s <= 2047) && (f3 <= 3'd2);
                w  = {b.imm[11:5], b.rs2, b.rs1, f3, b.imm[4:0], b.op};
            end
            7'b1100011: begin
                ok = (s >= -4096 && s <= 4095) && (s % 2 == 0) && (f3 inside {3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7});
                w  = {b.imm[12], b.imm[10:5], b.rs2, b.rs1, f3, b.imm[4:1], b.imm[11], b.op};
            end
            7'b0110111: begin
                ok = (b.imm % 4096 == 0);
                w  = {b.imm[31:12], b.rd, b.op};
            end
            7'b1101111: begin
                ok = (s >= -1048576 && s <= 1048575) && (s % 2 == 0);
                w  = {b.imm[20], b.imm[10:1], b.imm[11], b.imm[19:12], b.rd, b.op};
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t     b;
        logic [6:0]  ops [10];
        logic [31:0] t;
        int          v;
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h7F, 7'h00};
        b.op  = ops[$urandom_range(0, 9)];
        t     = $urandom;
        b.rs1 = t[4:0];
        b.rs2 = t[9:5];
        b.rd  = t[14:10];
        case ($urandom_range(0, 3))
            0: b.func[9:3] = 7'h00;
            1: b.func[9:3] = 7'h20;
            2: b.func[9:3] = 7'h01;
            default: b.func[9:3] = t[21:15];
        endcase
        b.func[2:0] = t[24:22];
        case ($urandom_range(0, 4))
            0: b.imm = $urandom;
            1: begin v = int'($urandom_range(0, 8191)) - 4096; b.imm = 32'(v); end
            2: b.imm = 32'($urandom_range(0, 40));
            3: begin t = $urandom; b.imm = {t[19:0], 12'h000}; end
            default: begin v = int'($urandom_range(0, 2097151)) - 1048576; b.imm = 32'(v); end
        endcase
        return b;
    endfunction

    // Drives one cycle at the falling edge and samples just after; also advances the model.
    task automatic cycle(input logic iv, input bundle_t b, input logic orr,
                         output logic in_fire, output logic out_fire,
                         output logic [32:0] obs, output logic [32:0] exp, output logic unexp);
        @(negedge clk);
        in_valid  = iv;
        op        = b.op;
        rs1       = b.rs1;
        rs2       = b.rs2;
        rd        = b.rd;
        func      = b.func;
        imm       = b.imm;
        out_ready = orr;
        #1;
        in_fire  = iv && in_ready;
        out_fire = out_valid && orr;
        obs      = {out_err, out_instr};
        exp      = '0;
        unexp    = 1'b0;
        if (out_fire) begin
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            else unexp = 1'b1;
            if (!unexp && exp[32] && exp_err < 65535) exp_err++;
        end
        if (in_fire) begin
            exp_q.push_back(ref_encode(b));
            if (exp_enc < 65535) exp_enc++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_enc = 0;
        exp_err = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_cmp++;
        if ({out_valid, out_err, out_instr, enc_cnt, err_cnt} !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset_state: got v=%b e=%b i=%h enc=%0d err=%0d expected all 0",
                     out_valid, out_err, out_instr, enc_cnt, err_cnt);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        exp_q.delete();
        exp_enc = 0;
        exp_err = 0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_directed();
        bundle_t     vec [6];
        logic [32:0] want [6];
        logic        inf, outf, unexp;
        logic [32:0] obs, exp;
        int          lat;
        bundle_t     idle;
        idle = '0;
        vec[0] = '{op: 7'h33, rs1: 5'd1, rs2: 5'd2, rd: 5'd3, func: 10'h000, imm: 32'd0};
        want[0] = {1'b0, 32'h002081B3};
        vec[1] = '{op: 7'h13, rs1: 5'd0, rs2: 5'd0, rd: 5'd1, func: 10'h000, imm: 32'hFFFF_FFFF};
        want[1] = {1'b0, 32'hFFF00093};
        vec[2] = '{op: 7'h13, rs1: 5'd0, rs2: 5'd0, rd: 5'd1, func: 10'h000, imm: 32'd2048};
        want[2] = {1'b1, 32'h00000013};
        vec[3] = '{op: 7'h63, rs1: 5'd1, rs2: 5'd2, rd: 5'd0, func: 10'h000, imm: 32'hFFFF_FFFC};
        want[3] = {1'b0, 32'hFE208EE3};
        vec[4] = '{op: 7'h63, rs1: 5'd1, rs2: 5'd2, rd: 5'd0, func: 10'h000, imm: 32'hFFFF_FFFD};
        want[4] = {1'b1, 32'h00000013};
        vec[5] = '{op: 7'h33, rs1: 5'd6, rs2: 5'd7, rd: 5'd5, func: 10'h008, imm: 32'd0};
        want[5] = M_EN ? {1'b0, 32'h027302B3} : {1'b1, 32'h00000013};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, vec[i], 1'b1, inf, outf, obs, exp, unexp);
            n_cmp++;
            if (inf !== 1'b1) begin n_bad++; $display("[TB] FAIL dir%0d_accept: got %b expected 1", i, inf); end
            lat  = 0;
            outf = 1'b0;
            while (!outf && lat < 8) begin
                cycle(1'b0, idle, 1'b1, inf, outf, obs, exp, unexp);
                lat++;
            end
            n_cmp++;
            if (lat !== 2 || !outf) begin n_bad++; $display("[TB] FAIL dir%0d_latency: got %0d expected 2", i, lat); end
            n_cmp++;
            if (obs !== want[i]) begin n_bad++; $display("[TB] FAIL dir%0d_word: got %h expected %h", i, obs, want[i]); end
            cycle(1'b0, idle, 1'b1, inf, outf, obs, exp, unexp);
            n_cmp++;
            if (err_cnt !== 16'(exp_err) || enc_cnt !== 16'(i + 1)) begin
                n_bad++;
                $display("[TB] FAIL dir%0d_counters: got enc=%0d err=%0d expected enc=%0d err=%0d",
                         i, enc_cnt, err_cnt, i + 1, exp_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        bundle_t     bs [4];
        logic        inf, outf, unexp;
        logic [32:0] obs, exp;
        int          idx, drop_at, outs, cyc;
        apply_reset();
        for (int i = 0; i < 4; i++) bs[i] = rand_bundle();
        idx = 0; drop_at = -1; outs = 0; cyc = 0;
        while (outs < 4 && cyc < 40) begin
            cycle(idx < 4, bs[idx < 4 ? idx : 0], cyc >= 3, inf, outf, obs, exp, unexp);
            if (idx < 4 && !inf && drop_at < 0) drop_at = idx;
            if (inf) idx++;
            if (outf) begin
                outs++;
                n_cmp++;
                if (unexp || obs !== exp) begin n_bad++; $display("[TB] FAIL b2b_out%0d: got %h expected %h", outs, obs, exp); end
            end
            cyc++;
        end
        n_cmp++;
        if (outs != 4) begin n_bad++; $display("[TB] FAIL b2b_count: got %0d expected 4", outs); end
        n_cmp++;
        if (drop_at != 2) begin n_bad++; $display("[TB] FAIL b2b_ready_drop: got %0d expected 2", drop_at); end
        cycle(1'b0, bs[0], 1'b1, inf, outf, obs, exp, unexp);
        n_cmp++;
        if (enc_cnt !== 16'd4) begin n_bad++; $display("[TB] FAIL b2b_enc_cnt: got %0d expected 4", enc_cnt); end
    endtask

    task automatic test_random();
        bundle_t     b;
        logic        inf, outf, unexp, iv, orr, prev_stall;
        logic [32:0] obs, exp, prev_obs;
        apply_reset();
        prev_stall = 1'b0;
        prev_obs   = '0;
        for (int i = 0; i < 400; i++) begin
            b   = rand_bundle();
            iv  = ($urandom_range(0, 9) < 7);
            orr = ($urandom_range(0, 9) < 6);
            cycle(iv, b, orr, inf, outf, obs, exp, unexp);
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || obs !== prev_obs) begin
                    n_bad++;
                    $display("[TB] FAIL rand_hold: got v=%b %h expected v=1 %h", out_valid, obs, prev_obs);
                end
            end
            prev_stall = out_valid && !orr;
            prev_obs   = obs;
            if (outf) begin
                n_cmp++;
                if (unexp || obs !== exp) begin n_bad++; $display("[TB] FAIL rand_out: got %h expected %h", obs, exp); end
            end
        end
        for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
            cycle(1'b0, b, 1'b1, inf, outf, obs, exp, unexp);
            if (outf) begin
                n_cmp++;
                if (unexp || obs !== exp) begin n_bad++; $display("[TB] FAIL drain_out: got %h expected %h", obs, exp); end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_bad++; $display("[TB] FAIL drain_left: got %0d pending expected 0", exp_q.size()); end
        cycle(1'b0, b, 1'b1, inf, outf, obs, exp, unexp);
        n_cmp++;
        if (unexp || outf) begin n_bad++; $display("[TB] FAIL drain_extra: got out_valid=%b expected 0", outf); end
        n_cmp++;
        if (enc_cnt !== 16'(exp_enc) || err_cnt !== 16'(exp_err)) begin
            n_bad++;
            $display("[TB] FAIL rand_counters: got enc=%0d err=%0d expected enc=%0d err=%0d",
                     enc_cnt, err_cnt, exp_enc, exp_err);
        end
    endtask

    task automatic test_reset_midflight();
        bundle_t     b;
        logic        inf, outf, unexp;
        logic [32:0] obs, exp;
        int          seen;
        b = '{op: 7'h33, rs1: 5'd1, rs2: 5'd2, rd: 5'd3, func: 10'h000, imm: 32'd0};
        cycle(1'b1, b, 1'b0, inf, outf, obs, exp, unexp);
        cycle(1'b1, b, 1'b0, inf, outf, obs, exp, unexp);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL mid_reset_in_ready: got %b expected 0", in_ready); end
        rst_n = 1'b1;
        exp_q.delete();
        exp_enc = 0;
        exp_err = 0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL mid_release_in_ready: got %b expected 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, b, 1'b1, inf, outf, obs, exp, unexp);
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("[TB] FAIL mid_no_output: got %0d outputs expected 0", seen); end
        n_cmp++;
        if (enc_cnt !== 16'd0 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("[TB] FAIL mid_counters: got enc=%0d err=%0d expected 0 0", enc_cnt, err_cnt);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        rs1       = '0;
        rs2       = '0;
        rd        = '0;
        func      = '0;
        imm       = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
